instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control unit for the 8-bit mini processor. It generates the human-visible instruction tick and the `slow_clk` LED clock, and steps the datapath through FETCH/DECODE/EXEC/WRITE. It owns the 4-bit program counter and resolves jump, conditional-jump and halt instructions, using the carry/borrow flag returned by the ALU. It sits between the board inputs (`pause`, step button) and the ROM, instruction register, ALU and accumulator.

## Interface
- `TICK_DIV`, default 100000000: clk cycles per sequencer phase. Minimum 2.
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous active-low reset.
- `pause`  in  1  level; freezes the sequencer while high.
- `step`  in  1  raw push-button; synchronized internally.
- `op`  in  4  opcode, `IR[7:4]`.
- `imm`  in  4  operand / jump target, `IR[3:0]`.
- `cb`  in  1  ALU carry/borrow flag, registered in the datapath.
- `pc`  out  4  program counter, drives ROM address.
- `ir_load`  out  1  IR load strobe.
- `exec_en`  out  1  ALU operation strobe.
- `wr_en`  out  1  accumulator/output write strobe.
- `phase`  out  3  state: FETCH=0, DECODE=1, EXEC=2, WRITE=3, HALT=4.
- `halted`  out  1  high in HALT.
- `slow_clk`  out  1  visible square wave with period `TICK_DIV` clk cycles.

## Operation
- Divider: `cnt` counts 0..TICK_DIV-1 and then wraps.
  - `tick` = (`cnt`==TICK_DIV-1) & !`pause`.
  - `cnt` holds while `pause`=1.
  - `slow_clk` = (`cnt` >= TICK_DIV/2).
- State changes happen only on a clk edge where `tick`=1 (or a step tick, see Configuration).
  - FETCH: `ir_load`=1; go to DECODE.
  - DECODE: no strobe; go to EXEC.
  - EXEC, by `op`:
    - 4'hF HLT: go to HALT; `pc` held.
    - 4'hE JMP: `pc`<=`imm`; go to FETCH.
    - 4'hD JC: if `cb`, `pc`<=`imm`, else `pc`<=`pc`+1; go to FETCH.
    - 4'hC JNC: same as JC with the condition inverted.
    - All other opcodes: `exec_en`=1; go to WRITE.
  - WRITE: `wr_en`=1; `pc`<=`pc`+1 modulo 16 (15 wraps to 0); go to FETCH.
  - HALT: absorbing. Ticks are ignored; only reset exits.
- Strobes are high exactly during the clk cycle in which `tick`=1 and `phase` matches. They are never high in other cycles.
- `cb` is sampled at the EXEC advancing edge. `cb` is the flag from the previous ALU op, since `exec_en` is not raised for jumps.

## Timing
- Reset values: `pc`=0, `phase`=FETCH, `cnt`=0, `slow_clk`=0, `halted`=0, all strobes 0, synchronizer flops 0.
- Free-running: one phase per TICK_DIV clk cycles.
  - ALU instruction: 4 phases.
  - Jump instruction: 3 phases.
- First `tick` after reset release: at `cnt`=TICK_DIV-1, i.e. the TICK_DIV-th edge after release.
- `pause` asserted mid-phase: counter and state freeze within the same cycle. On deassert, counting resumes from the held `cnt`. No phase is skipped or repeated.
- `pause` is synchronous to `clk`; the top level synchronizes it.
- Reset asserted mid-instruction: all state clears immediately, and execution restarts at FETCH with `pc`=0.
- PC wrap: WRITE at `pc`=15 gives `pc`=0 with no flag.
- A jump to the current `pc` is legal and loops.

## Configuration
- Macro `SINGLE_STEP_EN`.
- Defined:
  - `step` passes through a 2-flop synchronizer and a rising-edge detector.
  - While `pause`=1, each detected edge produces one step tick. The step tick advances exactly one phase, with the same strobes as a normal tick.
  - The phase advances on the 3rd rising clk edge after `step` is first sampled high.
  - Step edges while `pause`=0 are ignored.
  - Holding `step` high produces exactly one advance.
  - `cnt` is unaffected by step ticks.
- Not defined: the `step` port exists but is ignored, and no synchronizer flops are instantiated.

## Test plan
1. Reset and run, TICK_DIV=4, program {0x12 ALU, 0x30 ALU, 0xF0 HLT}:
   - `ir_load` on edges 4, 20 and 36.
   - `exec_en` and `wr_en` one tick apart.
   - `pc` sequence 0→1→2.
   - `halted`=1 from edge 44; `pc` stays at 2 indefinitely.
2. Jumps, with `op`=E and `imm`=5 at `pc`=3:
   - After EXEC, `pc`=5, `phase`=FETCH.
   - No `wr_en` or `exec_en` pulse for that instruction.
3. Conditional jumps:
   - JC with `cb`=1 and `imm`=9: `pc`=9.
   - JC with `cb`=0 at `pc`=4: `pc`=5.
   - JNC with `cb`=0 and `imm`=2: `pc`=2.
4. Wrap: ALU instruction at `pc`=15 → `pc`=0 after WRITE; the next `ir_load` fetches address 0.
5. Pause and step (`SINGLE_STEP_EN`), with `pause`=1 in DECODE:
   - No progress or strobes over 100 cycles; `slow_clk` frozen.
   - A 10-cycle `step` pulse gives exactly one advance to EXEC, 3 edges after `step` rises.
   - `step` with `pause`=0 has no extra effect.
   - Without the macro, `step` is ignored.
6. Reset mid-EXEC: drop `rstn` for 2 cycles at `pc`=7.
   - All outputs return to their reset values asynchronously.
   - `ir_load` recurs at `pc`=0 after TICK_DIV cycles.

Source files
------------

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_sequencer: phase divider, FETCH/DECODE/EXEC/WRITE/HALT control, PC. |
// | Optional macro SINGLE_STEP_EN enables the paused single-step button path. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_sequencer #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pause,
    input  logic       step,
    input  logic [3:0] op,
    input  logic [3:0] imm,
    input  logic       cb,
    output logic [3:0] pc,
    output logic       ir_load,
    output logic       exec_en,
    output logic       wr_en,
    output logic [2:0] phase,
    output logic       halted,
    output logic       slow_clk
);
    localparam int               c_CNT_W    = $clog2(TICK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TICK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(TICK_DIV / 2);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_WRITE  = 3'd3;
    localparam logic [2:0] c_HALT   = 3'd4;

    localparam logic [3:0] c_OP_JNC = 4'hC;
    localparam logic [3:0] c_OP_JC  = 4'hD;
    localparam logic [3:0] c_OP_JMP = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_phase;
    logic [2:0]         w_phase_nxt;
    logic [3:0]         r_pc;
    logic [3:0]         w_pc_nxt;
    logic               w_tick;
    logic               w_step_tick;
    logic               w_adv;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (!pause) begin
            r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    assign w_tick   = (r_cnt == c_CNT_MAX) && !pause;
    assign slow_clk = (r_cnt >= c_CNT_HALF);

`ifdef SINGLE_STEP_EN
    logic r_step_meta;
    logic r_step_sync;
    logic r_step_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_meta <= step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
        end
    end

    // A button edge only counts while the free-running tick is frozen.
    assign w_step_tick = pause && r_step_sync && !r_step_prev;
`else
    logic w_step_unused;
    assign w_step_unused = step;
    assign w_step_tick   = 1'b0;
`endif

    assign w_adv = w_tick || w_step_tick;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= c_FETCH;
            r_pc    <= 4'd0;
        end else begin
            r_phase <= w_phase_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_pc_nxt    = r_pc;
        if (w_adv) begin
            case (r_phase)
                c_FETCH:  w_phase_nxt = c_DECODE;
                c_DECODE: w_phase_nxt = c_EXEC;
                c_EXEC: begin
                    case (op)
                        c_OP_HLT: w_phase_nxt = c_HALT;
                        c_OP_JMP: begin
                            w_pc_nxt    = imm;
                            w_phase_nxt = c_FETCH;
                        end
                        c_OP_JC: begin
                            w_pc_nxt    = cb ? imm : r_pc + 4'd1;
                            w_phase_nxt = c_FETCH;
                        end
                        c_OP_JNC: begin
                            w_pc_nxt    = cb ? r_pc + 4'd1 : imm;
                            w_phase_nxt = c_FETCH;
                        end
                        default: w_phase_nxt = c_WRITE;
                    endcase
                end
                c_WRITE: begin
                    w_pc_nxt    = r_pc + 4'd1;
                    w_phase_nxt = c_FETCH;
                end
                default: w_phase_nxt = r_phase;
            endcase
        end
    end

    // Strobes are single-cycle: they exist only while the advancing tick is high.
    always_comb begin
        ir_load = 1'b0;
        exec_en = 1'b0;
        wr_en   = 1'b0;
        if (w_adv) begin
            case (r_phase)
                c_FETCH: ir_load = 1'b1;
                c_EXEC:  exec_en = (op < c_OP_JNC);
                c_WRITE: wr_en   = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc     = r_pc;
    assign phase  = r_phase;
    assign halted = (r_phase == c_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_sequencer: table vectors, program traces and random run vs model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_sequencer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pause;
    logic       step;
    logic       cb;
    logic [3:0] op;
    logic [3:0] imm;
    logic [3:0] pc;
    logic       ir_load;
    logic       exec_en;
    logic       wr_en;
    logic [2:0] phase;
    logic       halted;
    logic       slow_clk;

    logic [7:0] rom [16];

    int m_cnt, m_phase, m_pc, cyc;
    bit sh0, sh1, sh2;
    int n_checks, n_errors;
    int fetched[$];

    typedef struct {
        int         n;
        logic       ir;
        logic       ex;
        logic       wr;
        logic [3:0] pc;
        logic [2:0] ph;
        logic       hl;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    assign op  = rom[pc][7:4];
    assign imm = rom[pc][3:0];

    instr_sequencer #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .pause    (pause),
        .step     (step),
        .op       (op),
        .imm      (imm),
        .cb       (cb),
        .pc       (pc),
        .ir_load  (ir_load),
        .exec_en  (exec_en),
        .wr_en    (wr_en),
        .phase    (phase),
        .halted   (halted),
        .slow_clk (slow_clk)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_pc = 0; cyc = 0;
        sh0 = 0; sh1 = 0; sh2 = 0;
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_pc", pc, 0);
        check("rst_phase", phase, 0);
        check("rst_halted", halted, 0);
        check("rst_ir_load", ir_load, 0);
        check("rst_exec_en", exec_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_slow_clk", slow_clk, 0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
    endtask

    // One clock: compare against the instruction-level model, then advance it.
    task automatic clk_cycle();
        logic       adv;
        logic       taken;
        logic [3:0] mop;
        logic [3:0] mimm;
        #1;
        mop  = rom[m_pc][7:4];
        mimm = rom[m_pc][3:0];
        adv  = (m_cnt == TD - 1) && !pause;
`ifdef SINGLE_STEP_EN
        if (pause && sh1 && !sh2) adv = 1'b1;
`endif
        check("pc", pc, m_pc);
        check("phase", phase, m_phase);
        check("halted", halted, m_phase == 4);
        check("ir_load", ir_load, adv && m_phase == 0);
        check("exec_en", exec_en, adv && m_phase == 2 && mop < 4'hC);
        check("wr_en", wr_en, adv && m_phase == 3);
        check("slow_clk", slow_clk, m_cnt >= TD / 2);
        if (ir_load === 1'b1) fetched.push_back(int'(pc));
        @(posedge clk);
        if (!pause) m_cnt = (m_cnt + 1) % TD;
        sh2 = sh1; sh1 = sh0; sh0 = step;
        if (adv) begin
            case (m_phase)
                0: m_phase = 1;
                1: m_phase = 2;
                2: begin
                    if (mop == 4'hF) m_phase = 4;
                    else if (mop == 4'hE) begin m_pc = mimm; m_phase = 0; end
                    else if (mop == 4'hD || mop == 4'hC) begin
                        taken   = (mop == 4'hD) ? cb : !cb;
                        m_pc    = taken ? int'(mimm) : (m_pc + 1) % 16;
                        m_phase = 0;
                    end else m_phase = 3;
                end
                3: begin m_pc = (m_pc + 1) % 16; m_phase = 0; end
                default: ;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input int ph, input int pcv, input int cntv, input int budget);
        int k = 0;
        while (!(m_phase == ph && m_pc == pcv && m_cnt == cntv) && k < budget) begin
            clk_cycle();
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_until: phase %0d pc %0d not reached within %0d cycles", ph, pcv, budget);
        end
    endtask

    task automatic check_fetches(input string name, input int exp[$]);
        check({name, "_count"}, fetched.size(), exp.size());
        foreach (exp[i])
            check(name, (i < fetched.size()) ? fetched[i] : -1, exp[i]);
    endtask

    initial begin
        #1000000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        rstn = 1'b0; pause = 1'b0; step = 1'b0; cb = 1'b0;
        n_checks = 0; n_errors = 0;
        model_reset();

        // n = clock edges since reset release at the sampling point
        vecs[0]  = '{0,   1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        vecs[1]  = '{3,   1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        vecs[2]  = '{4,   1'b0, 1'b0, 1'b0, 4'd0, 3'd1, 1'b0};
        vecs[3]  = '{7,   1'b0, 1'b0, 1'b0, 4'd0, 3'd1, 1'b0};
        vecs[4]  = '{11,  1'b0, 1'b1, 1'b0, 4'd0, 3'd2, 1'b0};
        vecs[5]  = '{15,  1'b0, 1'b0, 1'b1, 4'd0, 3'd3, 1'b0};
        vecs[6]  = '{16,  1'b0, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0};
        vecs[7]  = '{19,  1'b1, 1'b0, 1'b0, 4'd1, 3'd0, 1'b0};
        vecs[8]  = '{31,  1'b0, 1'b0, 1'b1, 4'd1, 3'd3, 1'b0};
        vecs[9]  = '{32,  1'b0, 1'b0, 1'b0, 4'd2, 3'd0, 1'b0};
        vecs[10] = '{35,  1'b1, 1'b0, 1'b0, 4'd2, 3'd0, 1'b0};
        vecs[11] = '{43,  1'b0, 1'b0, 1'b0, 4'd2, 3'd2, 1'b0};
        vecs[12] = '{44,  1'b0, 1'b0, 1'b0, 4'd2, 3'd4, 1'b1};
        vecs[13] = '{47,  1'b0, 1'b0, 1'b0, 4'd2, 3'd4, 1'b1};
        vecs[14] = '{100, 1'b0, 1'b0, 1'b0, 4'd2, 3'd4, 1'b1};

        foreach (rom[i]) rom[i] = 8'h10;
        rom[0] = 8'h12; rom[1] = 8'h30; rom[2] = 8'hF0;
        @(negedge clk);
        do_reset();
        foreach (vecs[i]) begin
            while (cyc < vecs[i].n) clk_cycle();
            check($sformatf("tbl%0d_ir_load", vecs[i].n), ir_load, vecs[i].ir);
            check($sformatf("tbl%0d_exec_en", vecs[i].n), exec_en, vecs[i].ex);
            check($sformatf("tbl%0d_wr_en", vecs[i].n), wr_en, vecs[i].wr);
            check($sformatf("tbl%0d_pc", vecs[i].n), pc, vecs[i].pc);
            check($sformatf("tbl%0d_phase", vecs[i].n), phase, vecs[i].ph);
            check($sformatf("tbl%0d_halted", vecs[i].n), halted, vecs[i].hl);
        end

        // JMP, JC taken, JNC taken
        foreach (rom[i]) rom[i] = 8'h10;
        rom[3] = 8'hE5; rom[5] = 8'hD9; rom[9] = 8'hC2;
        do_reset();
        fetched.delete();
        for (int i = 0; i < 135; i++) begin
            cb = (m_pc == 5);
            clk_cycle();
        end
        check_fetches("jump_fetch", '{0, 1, 2, 3, 5, 9, 2, 3, 5, 9});

        // JC not taken, then halt holds pc
        foreach (rom[i]) rom[i] = 8'h10;
        rom[4] = 8'hD9; rom[5] = 8'hF0;
        cb = 1'b0;
        do_reset();
        fetched.delete();
        repeat (120) clk_cycle();
        check_fetches("jc_nt_fetch", '{0, 1, 2, 3, 4, 5});
        check("jc_nt_halted", halted, 1);
        check("jc_nt_pc", pc, 5);

        // PC wrap after WRITE at 15
        foreach (rom[i]) rom[i] = 8'h10;
        do_reset();
        fetched.delete();
        repeat (265) clk_cycle();
        check_fetches("wrap_fetch", '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0});

        // Pause in DECODE, then the step button
        do_reset();
        run_until(1, 0, 1, 50);
        pause = 1'b1;
        repeat (100) clk_cycle();
        check("pause_phase", phase, 1);
        check("pause_slow_clk", slow_clk, 0);
        step = 1'b1;
`ifdef SINGLE_STEP_EN
        clk_cycle();
        check("step_edge1", phase, 1);
        clk_cycle();
        check("step_edge2", phase, 1);
        clk_cycle();
        check("step_edge3", phase, 2);
        repeat (7) clk_cycle();
        step = 1'b0;
        repeat (5) clk_cycle();
        check("step_once", phase, 2);
`else
        repeat (10) clk_cycle();
        step = 1'b0;
        repeat (5) clk_cycle();
        check("step_ignored", phase, 1);
`endif
        pause = 1'b0;
        step  = 1'b1;
        repeat (10) clk_cycle();
        step  = 1'b0;
        repeat (20) clk_cycle();

        // Reset in the middle of EXEC at pc 7 with slow_clk high
        do_reset();
        run_until(2, 7, 2, 300);
        check("pre_rst_slow_clk", slow_clk, 1);
        do_reset();
        fetched.delete();
        repeat (TD) clk_cycle();
        check_fetches("rst_refetch", '{0});

        // Random programs, flags, pause and step against the model
        for (int r = 0; r < 6; r++) begin
            foreach (rom[i]) begin
                rom[i] = 8'($urandom);
                if (rom[i][7:4] == 4'hF && $urandom_range(0, 3) != 0) rom[i][7:4] = 4'h1;
            end
            pause = 1'b0;
            step  = 1'b0;
            do_reset();
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 19) == 0) pause = ~pause;
                step = ($urandom_range(0, 5) == 0);
                cb   = 1'($urandom);
                clk_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
